// File: rtl/fsm_onehot_seq_tx.sv
// Serial framing transmitter: payload MSB-first plus a 1,0,1 end marker, with zero
// stuffing so that a "101" one-hot detector fires exactly once per frame, on the last marker bit.
module fsm_onehot_seq_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              stuff,
  output logic              frame_end,
  output logic [3:0]        rx_state
);

  localparam int CW = $clog2(DATA_W + 4);
  localparam logic [CW-1:0] CNT_M1 = CW'(DATA_W);
  localparam logic [CW-1:0] CNT_M2 = CW'(DATA_W + 1);
  localparam logic [CW-1:0] CNT_M3 = CW'(DATA_W + 2);

  localparam logic [3:0] ST_A = 4'b0001;
  localparam logic [3:0] ST_C = 4'b0100;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    DATA = 3'b010,
    MARK = 3'b100
  } state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n, src;
  logic [CW-1:0]     cnt, cnt_n, cnt_src;
  logic              out_n, out_valid_n, stuff_n, frame_end_n;
  logic [3:0]        rx_n, mirror_upd, s_sel;
  logic              consume, pending, do_stuff, present;

  function automatic logic [3:0] det_next(input logic [3:0] s, input logic b);
    return {s[2] & b, (s[1] | s[3]) & ~b, (s[0] | s[1] | s[3]) & b, (s[0] | s[2]) & ~b};
  endfunction

  assign in_ready = (state == IDLE);
  assign consume  = out_valid & out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      stuff     <= 1'b0;
      frame_end <= 1'b0;
      rx_state  <= ST_A;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      out       <= out_n;
      out_valid <= out_valid_n;
      stuff     <= stuff_n;
      frame_end <= frame_end_n;
      rx_state  <= rx_n;
    end
  end

  // In IDLE the pending bit comes straight from the word being accepted and the mirror
  // is unchanged; otherwise it follows the just-consumed bit.
  always_comb begin
    mirror_upd = det_next(rx_state, out);
    src        = (state == IDLE) ? in_data : shreg;
    cnt_src    = (state == IDLE) ? '0 : cnt;
    s_sel      = (state == IDLE) ? rx_state : mirror_upd;

    if (cnt_src < CNT_M1)       pending = src[DATA_W-1];
    else if (cnt_src == CNT_M2) pending = 1'b0;
    else                        pending = 1'b1;

    do_stuff = pending && (s_sel == ST_C) && (cnt_src <= CNT_M1);

    state_n     = state;
    shreg_n     = shreg;
    cnt_n       = cnt;
    out_n       = out;
    out_valid_n = out_valid;
    stuff_n     = stuff;
    frame_end_n = frame_end;
    rx_n        = rx_state;
    present     = 1'b0;

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_n = DATA;
          present = 1'b1;
        end
      end
      DATA, MARK: begin
        if (consume) begin
          rx_n = mirror_upd;
          if (frame_end) begin
            state_n     = IDLE;
            out_valid_n = 1'b0;
            out_n       = 1'b0;
            stuff_n     = 1'b0;
            frame_end_n = 1'b0;
            cnt_n       = '0;
          end else begin
            present = 1'b1;
            if (state == DATA && !stuff && cnt == CNT_M1) state_n = MARK;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (present) begin
      out_valid_n = 1'b1;
      if (do_stuff) begin
        out_n       = 1'b0;
        stuff_n     = 1'b1;
        frame_end_n = 1'b0;
        shreg_n     = src;
        cnt_n       = cnt_src;
      end else begin
        out_n       = pending;
        stuff_n     = 1'b0;
        frame_end_n = (cnt_src == CNT_M3);
        shreg_n     = src << 1;
        cnt_n       = cnt_src + 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  // The detector may only complete "101" on the final marker bit.
  no_early_detect: assert property (@(posedge clk) disable iff (!resetn)
    (out_valid && out_ready && out && rx_state == ST_C) |-> frame_end);
`endif

endmodule
